// File: rtl/ezpipe_lsu.sv
// ezpipe_lsu: RV32I load/store unit between EXECUTE and WRITE.
// Drives a ready-handshake data bus, extends load data and reports faults.
module ezpipe_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic [1:0]  resp_fault,
  output logic        stall,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_data_wr,
  output logic [3:0]  dbus_wstrb,
  output logic        dbus_rd,
  output logic        dbus_wr,
  input  logic [31:0] dbus_data_rd,
  input  logic        dbus_data_ready
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] F_OK  = 2'b00;
  localparam logic [1:0] F_MIS = 2'b01;
  localparam logic [1:0] F_ILL = 2'b10;
  localparam logic [1:0] F_TMO = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_store_q, is_store_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       addr_lo_q, addr_lo_d;
  logic [4:0]       rd_q, rd_d;
  logic             req_ready_q, req_ready_d;
  logic             stall_q, stall_d;
  logic             resp_valid_q, resp_valid_d;
  logic [4:0]       resp_rd_q, resp_rd_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic [1:0]       resp_fault_q, resp_fault_d;
  logic [31:0]      dbus_addr_q, dbus_addr_d;
  logic [31:0]      dbus_data_wr_q, dbus_data_wr_d;
  logic [3:0]       dbus_wstrb_q, dbus_wstrb_d;
  logic             dbus_rd_q, dbus_rd_d;
  logic             dbus_wr_q, dbus_wr_d;

  logic             illegal_c;
  logic             misaligned_c;
  logic [7:0]       ld_byte_c;
  logic [15:0]      ld_half_c;
  logic [31:0]      ld_ext_c;

  // Request legality and alignment checks on the incoming op.
  always_comb begin
    illegal_c = 1'b0;
    if (req_is_store) begin
      illegal_c = req_funct3[2] | (req_funct3[1:0] == 2'b11);
    end else begin
      illegal_c = (req_funct3 == 3'b011) | (req_funct3 == 3'b110) | (req_funct3 == 3'b111);
    end
    misaligned_c = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                   ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
  end

  // Load lane extraction and sign/zero extension from the captured bus word.
  always_comb begin
    ld_byte_c = dbus_data_rd[{addr_lo_q, 3'b000} +: 8];
    ld_half_c = dbus_data_rd[{addr_lo_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  ld_ext_c = {{24{ld_byte_c[7]}}, ld_byte_c};
      3'b001:  ld_ext_c = {{16{ld_half_c[15]}}, ld_half_c};
      3'b100:  ld_ext_c = {24'h000000, ld_byte_c};
      3'b101:  ld_ext_c = {16'h0000, ld_half_c};
      default: ld_ext_c = dbus_data_rd;
    endcase
  end

  // Next-state and registered-output logic for the IDLE/BUS/RESP handshake.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    is_store_d     = is_store_q;
    funct3_d       = funct3_q;
    addr_lo_d      = addr_lo_q;
    rd_d           = rd_q;
    resp_valid_d   = 1'b0;
    resp_rd_d      = resp_rd_q;
    resp_data_d    = resp_data_q;
    resp_fault_d   = resp_fault_q;
    dbus_addr_d    = dbus_addr_q;
    dbus_data_wr_d = dbus_data_wr_q;
    dbus_wstrb_d   = dbus_wstrb_q;
    dbus_rd_d      = dbus_rd_q;
    dbus_wr_d      = dbus_wr_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          is_store_d = req_is_store;
          funct3_d   = req_funct3;
          addr_lo_d  = req_addr[1:0];
          rd_d       = req_rd;
          if (illegal_c || misaligned_c) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = illegal_c ? F_ILL : F_MIS;
            resp_rd_d    = 5'd0;
            resp_data_d  = 32'd0;
          end else begin
            state_d     = S_BUS;
            cnt_d       = '0;
            dbus_addr_d = {req_addr[31:2], 2'b00};
            dbus_rd_d   = ~req_is_store;
            dbus_wr_d   = req_is_store;
            if (req_is_store) begin
              case (req_funct3[1:0])
                2'b00: begin
                  dbus_data_wr_d = {4{req_wdata[7:0]}};
                  dbus_wstrb_d   = 4'b0001 << req_addr[1:0];
                end
                2'b01: begin
                  dbus_data_wr_d = {2{req_wdata[15:0]}};
                  dbus_wstrb_d   = 4'b0011 << req_addr[1:0];
                end
                default: begin
                  dbus_data_wr_d = req_wdata;
                  dbus_wstrb_d   = 4'b1111;
                end
              endcase
            end else begin
              dbus_data_wr_d = 32'd0;
              dbus_wstrb_d   = 4'b0000;
            end
          end
        end
      end
      S_BUS: begin
        if (dbus_data_ready) begin
          state_d      = S_RESP;
          dbus_rd_d    = 1'b0;
          dbus_wr_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_fault_d = F_OK;
          resp_rd_d    = is_store_q ? 5'd0 : rd_q;
          resp_data_d  = is_store_q ? 32'd0 : ld_ext_c;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = S_RESP;
          dbus_rd_d    = 1'b0;
          dbus_wr_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_fault_d = F_TMO;
          resp_rd_d    = 5'd0;
          resp_data_d  = 32'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        dbus_rd_d = 1'b0;
        dbus_wr_d = 1'b0;
      end
    endcase

    req_ready_d = (state_d == S_IDLE);
    stall_d     = (state_d != S_IDLE);
  end

  // State and output registers; reset drops strobes and discards any access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      is_store_q     <= 1'b0;
      funct3_q       <= 3'b000;
      addr_lo_q      <= 2'b00;
      rd_q           <= 5'd0;
      req_ready_q    <= 1'b1;
      stall_q        <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_rd_q      <= 5'd0;
      resp_data_q    <= 32'd0;
      resp_fault_q   <= 2'b00;
      dbus_addr_q    <= 32'd0;
      dbus_data_wr_q <= 32'd0;
      dbus_wstrb_q   <= 4'b0000;
      dbus_rd_q      <= 1'b0;
      dbus_wr_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      is_store_q     <= is_store_d;
      funct3_q       <= funct3_d;
      addr_lo_q      <= addr_lo_d;
      rd_q           <= rd_d;
      req_ready_q    <= req_ready_d;
      stall_q        <= stall_d;
      resp_valid_q   <= resp_valid_d;
      resp_rd_q      <= resp_rd_d;
      resp_data_q    <= resp_data_d;
      resp_fault_q   <= resp_fault_d;
      dbus_addr_q    <= dbus_addr_d;
      dbus_data_wr_q <= dbus_data_wr_d;
      dbus_wstrb_q   <= dbus_wstrb_d;
      dbus_rd_q      <= dbus_rd_d;
      dbus_wr_q      <= dbus_wr_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign stall        = stall_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rd      = resp_rd_q;
  assign resp_data    = resp_data_q;
  assign resp_fault   = resp_fault_q;
  assign dbus_addr    = dbus_addr_q;
  assign dbus_data_wr = dbus_data_wr_q;
  assign dbus_wstrb   = dbus_wstrb_q;
  assign dbus_rd      = dbus_rd_q;
  assign dbus_wr      = dbus_wr_q;

endmodule

// File: tb/tb_ezpipe_lsu.sv
// Self-checking bench for ezpipe_lsu: vector table, scoreboard queue, and
// hand-written reset / idle-ready sequences.
module tb_ezpipe_lsu;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic [1:0]  resp_fault;
  logic        stall;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_data_wr;
  logic [3:0]  dbus_wstrb;
  logic        dbus_rd;
  logic        dbus_wr;
  logic [31:0] dbus_data_rd;
  logic        dbus_data_ready;

  ezpipe_lsu #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_data(resp_data), .resp_fault(resp_fault),
    .stall(stall), .dbus_addr(dbus_addr), .dbus_data_wr(dbus_data_wr), .dbus_wstrb(dbus_wstrb),
    .dbus_rd(dbus_rd), .dbus_wr(dbus_wr), .dbus_data_rd(dbus_data_rd),
    .dbus_data_ready(dbus_data_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          waits;     // non-ready strobe cycles before ready; >= T means never
    logic [31:0] e_data;
    logic [1:0]  e_fault;
    logic [31:0] e_bdata;   // expected store bus data
    logic [3:0]  e_wstrb;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  fault;
  } exp_t;

  vec_t vt[16];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [4:0] rd,
                              input logic [31:0] rdata, input int waits,
                              input logic [31:0] e_data, input logic [1:0] e_fault,
                              input logic [31:0] e_bdata, input logic [3:0] e_wstrb);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd; v.rdata = rdata;
    v.waits = waits; v.e_data = e_data; v.e_fault = e_fault; v.e_bdata = e_bdata;
    v.e_wstrb = e_wstrb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    exp_t g;
    int   cyc;
    int   strobes;
    int   exp_lat;
    int   exp_strobes;
    bit   got;
    bit   early_fault;
    @(negedge clk);
    chk($sformatf("v%0d req_ready", idx), 32'(req_ready), 32'd1);
    req_is_store = v.st; req_funct3 = v.f3; req_addr = v.addr;
    req_wdata = v.wdata; req_rd = v.rd; dbus_data_rd = v.rdata; req_valid = 1'b1;
    early_fault = (v.e_fault == 2'b01) || (v.e_fault == 2'b10);
    e.rd    = (v.st || v.e_fault != 2'b00) ? 5'd0 : v.rd;
    e.data  = v.e_data;
    e.fault = v.e_fault;
    sb.push_back(e);
    exp_strobes = early_fault ? 0 : ((v.waits >= T) ? T : v.waits + 1);
    exp_lat     = early_fault ? 1 : ((v.waits >= T) ? T + 1 : v.waits + 2);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; strobes = 0; got = 1'b0;
    if (exp_strobes > 0) begin
      chk($sformatf("v%0d dbus_rd", idx), 32'(dbus_rd), 32'(!v.st));
      chk($sformatf("v%0d dbus_wr", idx), 32'(dbus_wr), 32'(v.st));
      chk($sformatf("v%0d dbus_addr", idx), dbus_addr, {v.addr[31:2], 2'b00});
      chk($sformatf("v%0d dbus_wstrb", idx), 32'(dbus_wstrb), 32'(v.e_wstrb));
      chk($sformatf("v%0d stall", idx), 32'(stall), 32'd1);
      if (v.st) chk($sformatf("v%0d dbus_data_wr", idx), dbus_data_wr, v.e_bdata);
    end
    while (!got && cyc < 40) begin
      dbus_data_ready = 1'b0;
      if (resp_valid) begin
        got = 1'b1;
        chk($sformatf("v%0d latency", idx), 32'(cyc), 32'(exp_lat));
        chk($sformatf("v%0d strobe_cycles", idx), 32'(strobes), 32'(exp_strobes));
        if (sb.size() == 0) begin
          chk($sformatf("v%0d unexpected_resp", idx), 32'd1, 32'd0);
        end else begin
          g = sb.pop_front();
          chk($sformatf("v%0d resp_rd", idx), 32'(resp_rd), 32'(g.rd));
          chk($sformatf("v%0d resp_data", idx), resp_data, g.data);
          chk($sformatf("v%0d resp_fault", idx), 32'(resp_fault), 32'(g.fault));
        end
      end else begin
        if (dbus_rd || dbus_wr) begin
          strobes++;
          if (strobes - 1 == v.waits) dbus_data_ready = 1'b1;
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!got) begin
      chk($sformatf("v%0d resp_seen", idx), 32'd0, 32'd1);
      sb.delete();
    end
    @(negedge clk);
    chk($sformatf("v%0d resp_one_cycle", idx), 32'(resp_valid), 32'd0);
    chk($sformatf("v%0d back_idle", idx), 32'(req_ready), 32'd1);
  endtask

  initial begin
    bit saw;
    // st f3 addr wdata rd rdata waits e_data e_fault e_bdata e_wstrb
    vt[0]  = mk(0, 3'b010, 32'h100, 32'h0, 5'd5,  32'hDEADBEEF, 0,   32'hDEADBEEF, 2'b00, 32'h0, 4'h0);
    vt[1]  = mk(0, 3'b000, 32'h103, 32'h0, 5'd6,  32'h80123456, 0,   32'hFFFFFF80, 2'b00, 32'h0, 4'h0);
    vt[2]  = mk(0, 3'b100, 32'h103, 32'h0, 5'd7,  32'h80123456, 1,   32'h00000080, 2'b00, 32'h0, 4'h0);
    vt[3]  = mk(0, 3'b001, 32'h102, 32'h0, 5'd8,  32'h80123456, 0,   32'hFFFF8012, 2'b00, 32'h0, 4'h0);
    vt[4]  = mk(0, 3'b101, 32'h100, 32'h0, 5'd9,  32'h80123456, 2,   32'h00003456, 2'b00, 32'h0, 4'h0);
    vt[5]  = mk(0, 3'b000, 32'h101, 32'h0, 5'd10, 32'h80123456, 0,   32'h00000034, 2'b00, 32'h0, 4'h0);
    vt[6]  = mk(1, 3'b000, 32'h201, 32'h000000AB, 5'd3, 32'h0, 1, 32'h0, 2'b00, 32'hABABABAB, 4'b0010);
    vt[7]  = mk(1, 3'b001, 32'h202, 32'h1234CDEF, 5'd4, 32'h0, 0, 32'h0, 2'b00, 32'hCDEFCDEF, 4'b1100);
    vt[8]  = mk(1, 3'b010, 32'h204, 32'hCAFEF00D, 5'd2, 32'h0, 0, 32'h0, 2'b00, 32'hCAFEF00D, 4'b1111);
    vt[9]  = mk(0, 3'b010, 32'h102, 32'h0, 5'd11, 32'h0, 0,   32'h0, 2'b01, 32'h0, 4'h0);
    vt[10] = mk(0, 3'b011, 32'h100, 32'h0, 5'd12, 32'h0, 0,   32'h0, 2'b10, 32'h0, 4'h0);
    vt[11] = mk(1, 3'b011, 32'h103, 32'h0, 5'd13, 32'h0, 0,   32'h0, 2'b10, 32'h0, 4'h0);
    vt[12] = mk(0, 3'b101, 32'h101, 32'h0, 5'd14, 32'h0, 0,   32'h0, 2'b01, 32'h0, 4'h0);
    vt[13] = mk(0, 3'b010, 32'h300, 32'h0, 5'd15, 32'h55555555, 255, 32'h0, 2'b11, 32'h0, 4'h0);
    vt[14] = mk(0, 3'b010, 32'h300, 32'h0, 5'd16, 32'h11223344, 3,   32'h11223344, 2'b00, 32'h0, 4'h0);
    vt[15] = mk(1, 3'b001, 32'h203, 32'h0, 5'd17, 32'h0, 0,   32'h0, 2'b01, 32'h0, 4'h0);

    reset = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    dbus_data_rd = 32'h0; dbus_data_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst strobes", 32'({dbus_rd, dbus_wr}), 32'd0);
    chk("rst dbus_addr", dbus_addr, 32'h0);
    chk("rst wstrb", 32'(dbus_wstrb), 32'd0);
    chk("rst resp_data", resp_data, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) run_vec(i, vt[i]);

    // Ready while idle must not start or complete anything.
    @(negedge clk);
    dbus_data_ready = 1'b1;
    saw = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid || dbus_rd || dbus_wr || !req_ready) saw = 1'b1;
    end
    dbus_data_ready = 1'b0;
    chk("idle_ready_ignored", 32'(saw), 32'd0);

    // Reset during BUS: strobe drops asynchronously, no response follows.
    @(negedge clk);
    req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400; req_rd = 5'd9;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid strobe_before", 32'(dbus_rd), 32'd1);
    chk("rstmid stall_before", 32'(stall), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rstmid dbus_rd", 32'(dbus_rd), 32'd0);
    chk("rstmid dbus_wr", 32'(dbus_wr), 32'd0);
    chk("rstmid stall", 32'(stall), 32'd0);
    chk("rstmid req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    saw = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid || dbus_rd) saw = 1'b1;
    end
    chk("rstmid no_resp", 32'(saw), 32'd0);
    chk("rstmid ready_after", 32'(req_ready), 32'd1);
    run_vec(100, vt[0]);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
